// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic phase sequencer.
// Holds the controller state encoding and the 3-bit lamp codes
// {green, yellow, red} driven onto each approach.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_GREEN       = 3'd0,
    ST_FLASH       = 3'd1,
    ST_YELLOW      = 3'd2,
    ST_ALLRED      = 3'd3,
    ST_NIGHT_BLINK = 3'd4
  } state_e;

  localparam logic [2:0] LAMP_G   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the board clock down to a one-cycle tick strobe.
// Ports:
//   CLK   - board clock
//   RST_N - asynchronous active-low reset (count returns to 0)
//   TICK  - high for the single CLK cycle in which the count sits at
//           CLK_HZ/TICK_HZ-1
module tick_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);

  localparam int            TC   = CLK_HZ / TICK_HZ - 1;
  localparam int            PW   = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [PW-1:0] TC_V = PW'(TC);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (cnt_q == TC_V) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign TICK = (cnt_q == TC_V);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach round-robin traffic-light sequencer with
// green-flash, yellow and all-red clearance, pedestrian walk requests and a
// night flashing mode. All sequencing advances only on the internal tick.
// Ports:
//   CLK     - board clock
//   RST_N   - asynchronous active-low reset
//   NIGHT   - asynchronous night request (synchronised here)
//   PED_REQ - asynchronous pedestrian buttons, one per approach
//   LIGHTS  - registered lamps, bits [3i+2:3i] = {green, yellow, red}
//   WALK    - registered walk indication per crossing
//   PHASE   - approach currently owning green
//   TICK    - one-cycle tick strobe
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 2,
  parameter int N_APP     = 2,
  parameter int GREEN_T   = 16,
  parameter int FLASH_T   = 6,
  parameter int YELLOW_T  = 6,
  parameter int ALLRED_T  = 2,
  parameter int PED_EXT_T = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 NIGHT,
  input  logic [N_APP-1:0]     PED_REQ,
  output logic [3*N_APP-1:0]   LIGHTS,
  output logic [N_APP-1:0]     WALK,
  output logic [2:0]           PHASE,
  output logic                 TICK
);

  // Counter reload values: each state holds for exactly its duration in ticks.
  localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] GREEN_EXT_LD = CNT_W'(GREEN_T + PED_EXT_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD     = CNT_W'((FLASH_T > 0) ? FLASH_T - 1 : 0);
  localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD    = CNT_W'(ALLRED_T - 1);

  function automatic logic [N_APP-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int k = 0; k < N_APP; k++)
      if (idx == 3'(k)) onehot[k] = 1'b1;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] p);
    succ = (p == 3'(N_APP - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  logic tick;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_prescaler (
    .CLK   (CLK),
    .RST_N (RST_N),
    .TICK  (tick)
  );

  // Input synchronisers; ped_s3 is the previous synchronised level for edge detect.
  logic             night_s1_q, night_s2_q;
  logic [N_APP-1:0] ped_s1_q, ped_s2_q, ped_s3_q;
  logic [N_APP-1:0] ped_rise;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      night_s1_q <= 1'b0;
      night_s2_q <= 1'b0;
      ped_s1_q   <= '0;
      ped_s2_q   <= '0;
      ped_s3_q   <= '0;
    end else begin
      night_s1_q <= NIGHT;
      night_s2_q <= night_s1_q;
      ped_s1_q   <= PED_REQ;
      ped_s2_q   <= ped_s1_q;
      ped_s3_q   <= ped_s2_q;
    end
  end

  assign ped_rise = ped_s2_q & ~ped_s3_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [N_APP-1:0] pend_q, pend_d;
  logic             toggle_q, toggle_d;
  // Set while leaving night mode so that the next green restarts at approach 0.
  logic             restart_q, restart_d;
  logic [N_APP-1:0] clr_mask;
  logic [2:0]       next_owner;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    toggle_d   = toggle_q;
    restart_d  = restart_q;
    clr_mask   = '0;
    next_owner = restart_q ? 3'd0 : succ(phase_q);
    if (tick) begin
      case (state_q)
        ST_GREEN: begin
          if (cnt_q == '0) begin
            if (FLASH_T > 0) begin
              state_d = ST_FLASH;
              cnt_d   = FLASH_LD;
            end else begin
              state_d  = ST_YELLOW;
              cnt_d    = YELLOW_LD;
              clr_mask = ~onehot(phase_q);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FLASH: begin
          if (cnt_q == '0) begin
            state_d  = ST_YELLOW;
            cnt_d    = YELLOW_LD;
            clr_mask = ~onehot(phase_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_YELLOW: begin
          if (cnt_q == '0) begin
            state_d = ST_ALLRED;
            cnt_d   = ALLRED_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_ALLRED: begin
          if (cnt_q == '0) begin
            if (night_s2_q) begin
              state_d  = ST_NIGHT_BLINK;
              toggle_d = 1'b0;
            end else begin
              state_d   = ST_GREEN;
              phase_d   = next_owner;
              restart_d = 1'b0;
              // Waiting pedestrians on other crossings stretch this green.
              cnt_d     = (|(pend_q & ~onehot(next_owner))) ? GREEN_EXT_LD : GREEN_LD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_NIGHT_BLINK: begin
          if (!night_s2_q) begin
            state_d   = ST_ALLRED;
            cnt_d     = ALLRED_LD;
            restart_d = 1'b1;
            toggle_d  = 1'b0;
          end else begin
            toggle_d = ~toggle_q;
          end
        end
        default: begin
          state_d = ST_ALLRED;
          cnt_d   = ALLRED_LD;
        end
      endcase
    end
    // A request edge on the clearing cycle survives the clear.
    pend_d = (pend_q & ~clr_mask) | ped_rise;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_ALLRED;
      cnt_q     <= ALLRED_LD;
      phase_q   <= 3'd0;
      pend_q    <= '0;
      toggle_q  <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      toggle_q  <= toggle_d;
      restart_q <= restart_d;
    end
  end

  logic [3*N_APP-1:0] lights_d, lights_q;
  logic [N_APP-1:0]   walk_d, walk_q;
  logic [2:0]         lamp;
  logic               flash_off;

  always_comb begin
    lights_d  = '0;
    walk_d    = '0;
    lamp      = LAMP_R;
    // Odd tick inside FLASH: (FLASH_LD - cnt) is odd exactly when the LSBs differ.
    flash_off = FLASH_LD[0] ^ cnt_q[0];
    for (int i = 0; i < N_APP; i++) begin
      lamp = LAMP_R;
      case (state_q)
        ST_GREEN:       if (phase_q == 3'(i)) lamp = LAMP_G;
        ST_FLASH:       if (phase_q == 3'(i)) lamp = flash_off ? LAMP_OFF : LAMP_G;
        ST_YELLOW:      if (phase_q == 3'(i)) lamp = LAMP_Y;
        ST_NIGHT_BLINK: begin
          if (i == 0) lamp = toggle_q ? LAMP_Y : LAMP_OFF;
          else        lamp = toggle_q ? LAMP_OFF : LAMP_R;
        end
        default:        lamp = LAMP_R;
      endcase
      lights_d[3*i +: 3] = lamp;
    end
    if (state_q == ST_GREEN || state_q == ST_FLASH)
      walk_d = pend_q & ~onehot(phase_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lights_q <= {N_APP{LAMP_R}};
      walk_q   <= '0;
    end else begin
      lights_q <= lights_d;
      walk_q   <= walk_d;
    end
  end

  assign LIGHTS = lights_q;
  assign WALK   = walk_q;
  assign PHASE  = phase_q;
  assign TICK   = tick;

endmodule
